// File: rtl/timer_drv_pkg.sv
// Shared definitions for the interval-timer master driver: timer register
// map, control-word bit positions, default control words, driver state
// encoding and small helpers that build one Avalon-MM bus command.
package timer_drv_pkg;

  // Interval timer register map (word addresses on the 3-bit bus).
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // Control register bit positions.
  localparam int unsigned CTRL_ITO_BIT   = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT  = 3;

  // Control words: run = START|CONT|ITO, stop = STOP with ITO cleared.
  localparam logic [3:0] CTRL_RUN_DFLT  = 4'h7;
  localparam logic [3:0] CTRL_STOP_DFLT = 4'h8;

  // Driver sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_PL   = 4'd1,
    ST_WR_PH   = 4'd2,
    ST_WR_CTRL = 4'd3,
    ST_RUN     = 4'd4,
    ST_CLR_ST  = 4'd5,
    ST_SNAP_WR = 4'd6,
    ST_RD_SL   = 4'd7,
    ST_RD_SH   = 4'd8,
    ST_WR_STOP = 4'd9
  } drv_state_e;

  // One cycle worth of Avalon-MM master signals.
  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } avm_cmd_t;

  // Bus parked: no chipselect, write_n high, address/data zero.
  function automatic avm_cmd_t avm_idle();
    avm_cmd_t c;
    c.cs   = 1'b0;
    c.wr_n = 1'b1;
    c.addr = 3'd0;
    c.data = 16'h0000;
    return c;
  endfunction

  // Single-cycle write command.
  function automatic avm_cmd_t avm_write(input logic [2:0] a, input logic [15:0] d);
    avm_cmd_t c;
    c.cs   = 1'b1;
    c.wr_n = 1'b0;
    c.addr = a;
    c.data = d;
    return c;
  endfunction

  // Read command; write data is held at zero while reading.
  function automatic avm_cmd_t avm_read(input logic [2:0] a);
    avm_cmd_t c;
    c.cs   = 1'b1;
    c.wr_n = 1'b1;
    c.addr = a;
    c.data = 16'h0000;
    return c;
  endfunction

  // Zero-extend a 4-bit control word onto the 16-bit data bus.
  function automatic logic [15:0] ctrl_word(input logic [3:0] c);
    return {12'h000, c};
  endfunction

endpackage

// File: rtl/timer_master_driver.sv
// Avalon-MM master that programs an interval timer, services its interrupt
// (clearing the status register and counting serviced ticks) and stops it on
// request. Optional feature macro TIMER_DRV_SNAPSHOT_EN: after each status
// clear, latch and read back the 32-bit counter snapshot and report it on
// the snapshot output together with the tick pulse. Without the macro the
// snapshot output is tied to zero.
module timer_master_driver
  import timer_drv_pkg::*;
#(
  parameter int unsigned TICK_W    = 32,
  parameter logic [3:0]  CTRL_RUN  = CTRL_RUN_DFLT,
  parameter logic [3:0]  CTRL_STOP = CTRL_STOP_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic              busy,
  output logic              cfg_err,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  input  logic [15:0]       readdata,
  input  logic              irq
);

  drv_state_e  state_r;
  avm_cmd_t    bus_r;
  logic [15:0] period_hi_r;   // low half goes out straight from cfg_period
  logic        stop_pend_r;

  localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

`ifdef TIMER_DRV_SNAPSHOT_EN
  logic        rd_phase_r;    // 0: first read cycle, 1: capture cycle
  logic [15:0] snap_lo_r;
  logic [31:0] snapshot_r;
`endif

  // Sequencer: state, registered bus command and all status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      bus_r       <= avm_idle();
      period_hi_r <= 16'h0000;
      stop_pend_r <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      tick        <= 1'b0;
      tick_count  <= {TICK_W{1'b0}};
`ifdef TIMER_DRV_SNAPSHOT_EN
      rd_phase_r  <= 1'b0;
      snap_lo_r   <= 16'h0000;
      snapshot_r  <= 32'h0000_0000;
`endif
    end else begin
      // Pulses and the bus default to inactive; states override below.
      cfg_err <= 1'b0;
      tick    <= 1'b0;
      bus_r   <= avm_idle();

      // A stop request outside IDLE is remembered until it can be honoured.
      if (cfg_stop && (state_r != ST_IDLE)) begin
        stop_pend_r <= 1'b1;
      end else begin
        stop_pend_r <= stop_pend_r;
      end

      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          if (cfg_start && (cfg_period != 32'h0000_0000)) begin
            period_hi_r <= cfg_period[31:16];
            tick_count  <= {TICK_W{1'b0}};
            bus_r       <= avm_write(ADDR_PERIODL, cfg_period[15:0]);
            busy        <= 1'b1;
            state_r     <= ST_WR_PL;
          end else if (cfg_start) begin
            cfg_err     <= 1'b1;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end

        ST_WR_PL: begin
          bus_r   <= avm_write(ADDR_PERIODH, period_hi_r);
          busy    <= 1'b1;
          state_r <= ST_WR_PH;
        end

        ST_WR_PH: begin
          bus_r   <= avm_write(ADDR_CONTROL, ctrl_word(CTRL_RUN));
          busy    <= 1'b1;
          state_r <= ST_WR_CTRL;
        end

        ST_WR_CTRL: begin
          busy    <= 1'b1;
          state_r <= ST_RUN;
        end

        ST_RUN: begin
          busy <= 1'b1;
          // A pending or fresh stop outranks a waiting interrupt.
          if (stop_pend_r || cfg_stop) begin
            bus_r   <= avm_write(ADDR_CONTROL, ctrl_word(CTRL_STOP));
            state_r <= ST_WR_STOP;
          end else if (irq) begin
            bus_r   <= avm_write(ADDR_STATUS, 16'h0000);
            state_r <= ST_CLR_ST;
          end else begin
            state_r <= ST_RUN;
          end
        end

`ifdef TIMER_DRV_SNAPSHOT_EN
        ST_CLR_ST: begin
          // Any write to snapl latches the running counter into snap regs.
          bus_r   <= avm_write(ADDR_SNAPL, 16'h0000);
          busy    <= 1'b1;
          state_r <= ST_SNAP_WR;
        end

        ST_SNAP_WR: begin
          bus_r      <= avm_read(ADDR_SNAPL);
          rd_phase_r <= 1'b0;
          busy       <= 1'b1;
          state_r    <= ST_RD_SL;
        end

        ST_RD_SL: begin
          busy <= 1'b1;
          if (rd_phase_r) begin
            snap_lo_r  <= readdata;
            rd_phase_r <= 1'b0;
            bus_r      <= avm_read(ADDR_SNAPH);
            state_r    <= ST_RD_SH;
          end else begin
            rd_phase_r <= 1'b1;
            bus_r      <= avm_read(ADDR_SNAPL);
            state_r    <= ST_RD_SL;
          end
        end

        ST_RD_SH: begin
          busy <= 1'b1;
          if (rd_phase_r) begin
            snapshot_r <= {readdata, snap_lo_r};
            rd_phase_r <= 1'b0;
            tick       <= 1'b1;
            tick_count <= tick_count + TICK_ONE;
            state_r    <= ST_RUN;
          end else begin
            rd_phase_r <= 1'b1;
            bus_r      <= avm_read(ADDR_SNAPH);
            state_r    <= ST_RD_SH;
          end
        end
`else
        ST_CLR_ST: begin
          // Count wraps silently at all-ones.
          tick       <= 1'b1;
          tick_count <= tick_count + TICK_ONE;
          busy       <= 1'b1;
          state_r    <= ST_RUN;
        end
`endif

        ST_WR_STOP: begin
          stop_pend_r <= 1'b0;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end

        default: begin
          stop_pend_r <= 1'b0;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign chipselect = bus_r.cs;
  assign write_n    = bus_r.wr_n;
  assign address    = bus_r.addr;
  assign writedata  = bus_r.data;

`ifdef TIMER_DRV_SNAPSHOT_EN
  assign snapshot = snapshot_r;
`else
  logic unused_readdata_s;
  assign snapshot          = 32'h0000_0000;
  assign unused_readdata_s = ^readdata;
`endif

endmodule

// File: tb/tb_timer_master_driver.sv
// Self-checking bench for timer_master_driver: a monitor compares every bus
// cycle and every tick pulse against queues of expected values pushed by the
// stimulus; a table of start/irq/stop scenarios plus hand-written corner
// sequences (stop during setup, stop in IDLE, reset mid-transaction).
module tb_timer_master_driver;

  localparam int TICK_W = 32;
`ifdef TIMER_DRV_SNAPSHOT_EN
  localparam logic [31:0] SNAP_EXP = 32'h0005_1234;
`else
  localparam logic [31:0] SNAP_EXP = 32'h0000_0000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       cfg_period;
  logic              cfg_start;
  logic              cfg_stop;
  logic              busy;
  logic              cfg_err;
  logic              tick;
  logic [TICK_W-1:0] tick_count;
  logic [31:0]       snapshot;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;

  always #5 clk = ~clk;

  timer_master_driver #(.TICK_W(TICK_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_period (cfg_period),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .tick       (tick),
    .tick_count (tick_count),
    .snapshot   (snapshot),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  typedef struct packed {
    logic [TICK_W-1:0] cnt;
    logic [31:0]       snap;
  } tick_t;

  typedef struct {
    logic [31:0] period;
    logic        err;
    int          n_irq;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [31:0] exp_tc;
  } vec_t;

  bus_t  bus_q[$];
  tick_t tick_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    err_seen = 0;
  int    tick_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard for bus cycles and tick pulses, cfg_err counter.
  initial begin : monitor
    bus_t  a;
    bus_t  e;
    tick_t t;
    forever begin
      @(negedge clk);
      if (cfg_err) err_seen++;
      if (chipselect) begin
        a.wr   = ~write_n;
        a.addr = address;
        a.data = writedata;
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_unexpected: got wr=%0d addr=%0d data=%04h, expected no bus cycle",
                   a.wr, a.addr, a.data);
        end else begin
          e = bus_q.pop_front();
          check("bus_cycle", {44'h0, a}, {44'h0, e});
        end
      end
      if (tick) begin
        tick_seen++;
        if (tick_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tick_unexpected: got tick with count %0h, expected no tick", tick_count);
        end else begin
          t = tick_q.pop_front();
          check("tick_count_at_tick", {32'h0, tick_count}, {32'h0, t.cnt});
          check("snapshot_at_tick", {32'h0, snapshot}, {32'h0, t.snap});
        end
      end
    end
  end

  // Timer read model: data appears one cycle after the read address.
  initial begin : rd_model
    readdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (chipselect && write_n && (address == 3'd4))      readdata = 16'h1234;
      else if (chipselect && write_n && (address == 3'd5)) readdata = 16'h0005;
      else                                                  readdata = 16'h0000;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, expected test to finish");
    $fatal(1);
  end

  task automatic push_start(input logic [15:0] lo, input logic [15:0] hi);
    bus_q.push_back({1'b1, 3'd2, lo});
    bus_q.push_back({1'b1, 3'd3, hi});
    bus_q.push_back({1'b1, 3'd1, 16'h0007});
  endtask

  task automatic push_irq(input int cnt);
    bus_q.push_back({1'b1, 3'd0, 16'h0000});
`ifdef TIMER_DRV_SNAPSHOT_EN
    bus_q.push_back({1'b1, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd5, 16'h0000});
    bus_q.push_back({1'b0, 3'd5, 16'h0000});
`endif
    tick_q.push_back({cnt[TICK_W-1:0], SNAP_EXP});
  endtask

  task automatic wait_tick(input int prev);
    for (int i = 0; i < 30 && tick_seen == prev; i++) @(negedge clk);
    check("tick_arrived", tick_seen, prev + 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    check(name, {63'h0, busy}, 64'h0);
  endtask

  task automatic do_start(input logic [31:0] p);
    cfg_period = p;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic pulse_irq(input int cnt);
    int base;
    push_irq(cnt);
    base = tick_seen;
    irq  = 1'b1;
    @(negedge clk);
    irq  = 1'b0;
    wait_tick(base);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.err) begin
      do_start(v.period);
      check("err_pulse", {63'h0, cfg_err}, 64'h1);
      check("err_busy_low", {63'h0, busy}, 64'h0);
      @(negedge clk);
      check("err_one_cycle", {63'h0, cfg_err}, 64'h0);
    end else begin
      push_start(v.exp_lo, v.exp_hi);
      do_start(v.period);
      check("start_busy", {63'h0, busy}, 64'h1);
      repeat (3) @(negedge clk);
      for (int k = 1; k <= v.n_irq; k++) pulse_irq(k);
      bus_q.push_back({1'b1, 3'd1, 16'h0008});
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      wait_idle("stop_to_idle");
      check("vec_tick_count", {32'h0, tick_count}, {32'h0, v.exp_tc});
      check("vec_bus_drained", bus_q.size(), 0);
    end
  endtask

  initial begin : stim
    vec_t vecs[5];
    int   e0;
    logic hit;

    vecs[0] = '{period: 32'h0001_86A0, err: 1'b0, n_irq: 3, exp_lo: 16'h86A0, exp_hi: 16'h0001, exp_tc: 32'd3};
    vecs[1] = '{period: 32'h0000_0000, err: 1'b1, n_irq: 0, exp_lo: 16'h0000, exp_hi: 16'h0000, exp_tc: 32'd0};
    vecs[2] = '{period: 32'hFFFF_FFFF, err: 1'b0, n_irq: 1, exp_lo: 16'hFFFF, exp_hi: 16'hFFFF, exp_tc: 32'd1};
    vecs[3] = '{period: 32'h0000_0001, err: 1'b0, n_irq: 0, exp_lo: 16'h0001, exp_hi: 16'h0000, exp_tc: 32'd0};
    vecs[4] = '{period: 32'h1234_5678, err: 1'b0, n_irq: 2, exp_lo: 16'h5678, exp_hi: 16'h1234, exp_tc: 32'd2};

    reset      = 1'b1;
    cfg_period = 32'h0;
    cfg_start  = 1'b0;
    cfg_stop   = 1'b0;
    irq        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_cfg_err", {63'h0, cfg_err}, 64'h0);
    check("rst_tick", {63'h0, tick}, 64'h0);
    check("rst_tick_count", {32'h0, tick_count}, 64'h0);
    check("rst_snapshot", {32'h0, snapshot}, 64'h0);
    check("rst_bus", {42'h0, chipselect, write_n, address, writedata}, {42'h0, 1'b0, 1'b1, 3'd0, 16'h0000});
    reset = 1'b0;
    @(negedge clk);

    // Stop while IDLE is ignored and must not leak into the next run.
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stop_ignored", {63'h0, busy}, 64'h0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      @(negedge clk);
    end
    check("err_count_after_table", err_seen, 1);

    // Stop during WR_PH: control write completes, then the stop write.
    // A start arriving while busy is ignored without cfg_err.
    e0 = err_seen;
    push_start(16'h0064, 16'h0000);
    bus_q.push_back({1'b1, 3'd1, 16'h0008});
    do_start(32'h0000_0064);
    @(negedge clk);
    cfg_stop   = 1'b1;
    cfg_period = 32'h0;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_stop   = 1'b0;
    cfg_start  = 1'b0;
    wait_idle("stop_in_setup_idle");
    check("busy_start_no_err", err_seen, e0);
    check("stop_in_setup_drained", bus_q.size(), 0);
    @(negedge clk);

    // Reset in the middle of servicing the second interrupt.
    push_start(16'h1000, 16'h0000);
    do_start(32'h0000_1000);
    repeat (3) @(negedge clk);
    pulse_irq(1);
    bus_q.push_back({1'b1, 3'd0, 16'h0000});
`ifdef TIMER_DRV_SNAPSHOT_EN
    bus_q.push_back({1'b1, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd4, 16'h0000});
`endif
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
`ifdef TIMER_DRV_SNAPSHOT_EN
      hit = chipselect && write_n && (address == 3'd4);
`else
      hit = chipselect && !write_n && (address == 3'd0);
`endif
      if (hit) break;
      @(negedge clk);
    end
    check("reset_target_reached", {63'h0, hit}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_cs_low", {63'h0, chipselect}, 64'h0);
    check("reset_tick_count", {32'h0, tick_count}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_snapshot", {32'h0, snapshot}, 64'h0);
    repeat (4) @(negedge clk);
    check("reset_no_more_bus", bus_q.size(), 0);

    // Recovery after reset: one more full run.
    run_vec(vecs[2]);

    check("final_tick_q_empty", tick_q.size(), 0);
    check("final_err_count", err_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_master_driver.md
TIMER_MASTER_DRIVER -- requirements
Module: timer_master_driver

Interface
REQ-001 SHALL have parameter TICK_W, 32, width of tick counter.
REQ-002 SHALL have parameter CTRL_RUN, 4'h7, control word written at start (START|CONT|ITO).
REQ-003 SHALL have parameter CTRL_STOP, 4'h8, control word written at stop (STOP, ITO cleared).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-006 SHALL have port cfg_period  in  32  timer reload value, latched on accepted start.
REQ-007 SHALL have port cfg_start  in  1  one-cycle start request.
REQ-008 SHALL have port cfg_stop  in  1  one-cycle stop request.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port cfg_err  out  1  one-cycle pulse when a start is rejected.
REQ-011 SHALL have port tick  out  1  one-cycle pulse per serviced timer interrupt.
REQ-012 SHALL have port tick_count  out  TICK_W  serviced interrupts since last accepted start.
REQ-013 SHALL have port snapshot  out  32  last captured counter snapshot.
REQ-014 SHALL have ports address out 3, chipselect out 1, write_n out 1, writedata out 16, readdata in 16, irq in 1: the Avalon-MM master toward the interval timer slave.

Function
REQ-015 SHALL implement FSM IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, SNAP_WR, RD_SL, RD_SH, WR_STOP; every non-RUN/IDLE state lasts one cycle except reads (two).
REQ-016 SHALL, in IDLE, accept cfg_start if cfg_period != 0: latch period, clear tick_count, go to WR_PL; if cfg_period == 0, pulse cfg_err next cycle and stay in IDLE.
REQ-017 SHALL issue writes as one cycle of chipselect=1, write_n=0: WR_PL addr 2 data period[15:0]; WR_PH addr 3 data period[31:16]; WR_CTRL addr 1 data {12'b0,CTRL_RUN}; then go to RUN.
REQ-018 SHALL, in RUN, on irq==1 go to CLR_ST (addr 0, data 0), then pulse tick and increment tick_count in the cycle after CLR_ST.
REQ-019 SHALL treat reads as fixed 1-cycle latency: drive addr with chipselect=1, write_n=1 for two cycles and capture readdata on the second cycle's edge.
REQ-020 SHALL wrap tick_count from all-ones to 0 without flagging.
REQ-021 SHALL latch cfg_stop in any non-IDLE state as stop_pend; at the next return to RUN (or immediately if in RUN), go to WR_STOP (addr 1, data {12'b0,CTRL_STOP}), then IDLE, clearing stop_pend.
REQ-022 SHALL give irq priority below stop_pend when both present in RUN.
REQ-023 SHALL ignore cfg_start when not IDLE (no cfg_err); cfg_stop in IDLE SHALL be ignored.
REQ-024 SHALL drive chipselect=0, write_n=1, address=0, writedata=0 in IDLE and RUN.

Reset
REQ-025 SHALL on reset: state IDLE, busy 0, cfg_err 0, tick 0, tick_count 0, snapshot 0, stop_pend 0, bus outputs per REQ-024; reset mid-transaction SHALL abort it with no further bus cycle (the timer itself is not reset by this block).

Configuration
REQ-026 SHALL, with TIMER_DRV_SNAPSHOT_EN defined, follow CLR_ST with SNAP_WR (addr 4, data 0), RD_SL (addr 4), RD_SH (addr 5), update snapshot with {hi,lo} and pulse tick together with the update.
REQ-027 SHALL, without TIMER_DRV_SNAPSHOT_EN, omit SNAP_WR/RD_SL/RD_SH, tie snapshot to 0, and pulse tick per REQ-018.

Structure
REQ-028 SHALL place timer register addresses (0..5), control bit positions, CTRL_RUN/CTRL_STOP and the state enum in package timer_drv_pkg.
REQ-029 SHALL be one module; a sub-module is not required.

Verification
REQ-030 SHALL verify: cfg_period=32'h0001_86A0, start -> writes addr2=86A0, addr3=0001, addr1=0007 on consecutive cycles, busy=1.
REQ-031 SHALL verify: three irq assertions in RUN -> three addr0 writes, three tick pulses, tick_count=3.
REQ-032 SHALL verify: cfg_start with cfg_period=0 -> cfg_err pulse, no bus activity, busy=0.
REQ-033 SHALL verify (SNAPSHOT_EN): readdata model returns 1234 then 0005 -> snapshot=32'h0005_1234 at tick pulse.
REQ-034 SHALL verify: cfg_stop during WR_PH -> WR_CTRL completes, then addr1=0008 write, IDLE.
REQ-035 SHALL verify: reset asserted during RD_SL -> chipselect=0 next cycle, tick_count=0.
